flow_width_conv: RTL

- Parametrised valid/ready data-width converter; replaces the fixed flow_8to16 / flow_16to8 pair with one block for any integer width ratio.
- Upsizes (packs RATIO narrow beats into one wide word) or downsizes (unpacks one wide word into RATIO narrow beats), with selectable beat order.
- Sits between a vldrdy master and a vldrdy slave in the flow test environment.
- Both sides are checked by vld_rdy_checker instances.

---
 rtl/flow_width_conv.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/flow_width_conv.sv
// flow_width_conv: valid/ready width converter that upsizes, downsizes or passes through.
// Define FLOW_WIDTH_CONV_LAST_EN to add src_last / dst_last / dst_keep framing ports.
module flow_width_conv #(
    parameter int SRC_DW    = 8,
    parameter int DST_DW    = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic              src_val,
    output logic              src_rdy,
    input  logic [SRC_DW-1:0] src_data,
    output logic              dst_val,
    input  logic              dst_rdy,
    output logic [DST_DW-1:0] dst_data
`ifdef FLOW_WIDTH_CONV_LAST_EN
    ,
    input  logic              src_last,
    output logic              dst_last,
    output logic [((DST_DW > SRC_DW) ? DST_DW / SRC_DW : 1)-1:0] dst_keep
`endif
);
    localparam int NW    = (SRC_DW < DST_DW) ? SRC_DW : DST_DW;
    localparam int WW    = (SRC_DW < DST_DW) ? DST_DW : SRC_DW;
    localparam int RATIO = WW / NW;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    logic en;
    assign en = cfg_en && !rst;

    // Bit offset of narrow beat k inside the wide word.
    function automatic int slot_base(input int k, input int w);
        return (LSB_FIRST ? k : RATIO - 1 - k) * w;
    endfunction

    if (WW % NW != 0) begin : g_bad_ratio
        $error("flow_width_conv: widths %0d/%0d are not an integer ratio", WW, NW);
    end else if (DST_DW > SRC_DW) begin : g_up
        typedef enum logic {FILL, FULL} up_state_e;
        up_state_e         state_q, state_d;
        logic [DST_DW-1:0] acc_q, acc_d;
        logic [CW-1:0]     cnt_q, cnt_d;
        logic              src_acc, word_done;

        assign dst_val  = cfg_en && (state_q == FULL);
        assign src_rdy  = en && (!dst_val || dst_rdy);
        assign src_acc  = src_val && src_rdy;
        assign dst_data = acc_q;
`ifdef FLOW_WIDTH_CONV_LAST_EN
        assign word_done = (cnt_q == LAST_IDX) || src_last;
`else
        assign word_done = (cnt_q == LAST_IDX);
`endif

        always_comb begin
            state_d = state_q;
            acc_d   = acc_q;
            cnt_d   = cnt_q;
            if (!cfg_en) begin
                state_d = FILL;
                acc_d   = '0;
                cnt_d   = '0;
            end else if (src_acc) begin
                // A new word starts from zero so short words come out zero-padded.
                if (cnt_q == '0) acc_d = '0;
                acc_d[slot_base(int'(cnt_q), SRC_DW) +: SRC_DW] = src_data;
                if (word_done) begin
                    state_d = FULL;
                    cnt_d   = '0;
                end else begin
                    state_d = FILL;
                    cnt_d   = cnt_q + CW'(1);
                end
            end else if (dst_val && dst_rdy) begin
                state_d = FILL;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= FILL;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                acc_q   <= acc_d;
                cnt_q   <= cnt_d;
            end
        end

`ifdef FLOW_WIDTH_CONV_LAST_EN
        logic [RATIO-1:0] keep_q;
        logic             last_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                keep_q <= '0;
                last_q <= 1'b0;
            end else if (!cfg_en) begin
                keep_q <= '0;
                last_q <= 1'b0;
            end else if (src_acc) begin
                keep_q <= ((cnt_q == '0) ? '0 : keep_q) | (RATIO'(1) << cnt_q);
                last_q <= src_last;
            end
        end

        assign dst_keep = keep_q;
        assign dst_last = last_q;
`endif
    end else if (SRC_DW > DST_DW) begin : g_down
        typedef enum logic {EMPTY, HOLD} dn_state_e;
        dn_state_e         state_q, state_d;
        logic [SRC_DW-1:0] hold_q, hold_d;
        logic [CW-1:0]     idx_q, idx_d;
        logic              src_acc, last_beat;

        assign dst_val   = cfg_en && (state_q == HOLD);
        assign last_beat = (idx_q == LAST_IDX);
        assign src_rdy   = en && (!dst_val || (dst_rdy && last_beat));
        assign src_acc   = src_val && src_rdy;
        assign dst_data  = hold_q[slot_base(int'(idx_q), DST_DW) +: DST_DW];

        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            idx_d   = idx_q;
            if (!cfg_en) begin
                state_d = EMPTY;
                hold_d  = '0;
                idx_d   = '0;
            end else if (src_acc) begin
                // Also covers reload on the final-beat handshake: no bubble.
                state_d = HOLD;
                hold_d  = src_data;
                idx_d   = '0;
            end else if (dst_val && dst_rdy) begin
                if (last_beat) begin
                    state_d = EMPTY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= EMPTY;
                hold_q  <= '0;
                idx_q   <= '0;
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
                idx_q   <= idx_d;
            end
        end

`ifdef FLOW_WIDTH_CONV_LAST_EN
        logic last_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                last_q <= 1'b0;
            end else if (!cfg_en) begin
                last_q <= 1'b0;
            end else if (src_acc) begin
                last_q <= src_last;
            end
        end

        assign dst_last = dst_val && last_beat && last_q;
        assign dst_keep = 1'b1;
`endif
    end else begin : g_pass
        logic [DST_DW-1:0] data_q;
        logic              val_q;

        assign dst_val  = cfg_en && val_q;
        assign src_rdy  = en && (!dst_val || dst_rdy);
        assign dst_data = data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                val_q  <= 1'b0;
                data_q <= '0;
            end else if (!cfg_en) begin
                val_q  <= 1'b0;
                data_q <= '0;
            end else if (src_val && src_rdy) begin
                val_q  <= 1'b1;
                data_q <= src_data;
            end else if (dst_val && dst_rdy) begin
                val_q  <= 1'b0;
            end
        end

`ifdef FLOW_WIDTH_CONV_LAST_EN
        logic last_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                last_q <= 1'b0;
            end else if (!cfg_en) begin
                last_q <= 1'b0;
            end else if (src_val && src_rdy) begin
                last_q <= src_last;
            end
        end

        assign dst_last = last_q;
        assign dst_keep = 1'b1;
`endif
    end
endmodule
